imm_gen_fifo: RTL and testbench
===============================

Name: imm_gen_fifo

Overview:
- Parametrised successor to the single-cycle immediate sign-extender, for the pipelined core.
- Decodes the instruction format from the opcode field itself; no one-hot format strobes.
- Produces the XLEN-wide immediate for every RV format (I/S/B/U/J), with correct B/J LSB zero-insertion.
- Results queue in an elastic FIFO with valid/ready on both sides, so fetch and decode can stall independently.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64; every immediate is sign-extended from bit 31 to XLEN.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- TAG_W, 8, width of the sideband tag (e.g. PC low bits) carried alongside each entry.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  instruction word presented.
- in_ready  out  1  block can accept the word.
- in_instr  in  32  raw instruction.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- out_illegal  out  1  opcode not recognised.
- out_tag  out  TAG_W  tag of the head entry.
- count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): pointers and count cleared, so count=0, out_valid=0 and in_ready=1 immediately, without waiting for a clock.
  - Entries in flight are discarded.
  - Data outputs read 0 whenever the FIFO is empty.
- Decode on in_instr[6:0]; the decoded result is written at push time:
  - 0010011, 0000011, 1100111 -> I: imm = sext(in[31:20]).
  - 0100011 -> S: sext({in[31:25], in[11:7]}).
  - 1100011 -> B: sext({in[31], in[7], in[30:25], in[11:8], 1'b0}).
  - 0110111, 0010111 -> U: sext({in[31:12], 12'b0}).
  - 1101111 -> J: sext({in[31], in[19:12], in[20], in[30:21], 1'b0}).
  - 0110011 -> R: imm = 0.
  - Any other opcode -> fmt=7, illegal=1, imm=0.
- Handshakes:
  - Push occurs when in_valid & in_ready.
  - Pop occurs when out_valid & out_ready.
  - in_ready = (count != DEPTH), independent of out_ready; a full FIFO never accepts, even on a same-cycle pop.
  - out_valid = (count != 0).
- Latency: a word pushed in cycle N is visible at the head (out_valid=1) in cycle N+1. No combinational input-to-output path.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Entries pop in strict push order.
- Head data must stay stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: IMM_GEN_ILLEGAL_CNT_EN.
- Defined:
  - Adds output illegal_cnt (16 bits), reset to 0.
  - Increments on each pushed word that decodes illegal.
  - Saturates at 0xFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-stream with count=3 -> out_valid=0, in_ready=1, count=0 with no clock edge; after release, old entries are never emitted.
- Single I, S and B words (defaults), out_ready=1:
  - Push 0xFFF00093 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1.
  - Push 0xFE512E23 -> out_imm=0xFFFFFFFC, out_fmt=2.
  - Push 0xFE000FE3 -> out_imm=0xFFFFFFFE, out_fmt=3.
- J/U widths:
  - Push 0x0010006F -> out_imm=0x00000800, fmt=5.
  - With XLEN=64, push 0x800000B7 -> out_imm=0xFFFFFFFF80000000, fmt=4.
- Full boundary (DEPTH=4): out_ready=0, push tags 1..5 back-to-back -> in_ready drops after the 4th push, count=4, tag 5 held. Raise out_ready -> tags pop in order 1,2,3,4, then tag 5 is accepted.
- Simultaneous push+pop at count=2 for 10 cycles -> count stays 2, order preserved, no drops.
- Illegal opcode: push 0x0000007F -> out_fmt=7, out_illegal=1, out_imm=0. With IMM_GEN_ILLEGAL_CNT_EN, illegal_cnt increments 0->1 and holds at 0xFFFF after saturation (forced counter preload).

Source files
------------

// File: rtl/imm_gen_fifo.sv
// imm_gen_fifo: RV immediate decoder feeding an elastic valid/ready FIFO.
// Each accepted word is decoded (format, immediate, illegal flag) at push time
// and queued with its sideband tag; the head entry is presented on out_*.
// Optional build macro IMM_GEN_ILLEGAL_CNT_EN adds a saturating 16-bit count
// of pushed illegal words on port illegal_cnt.
module imm_gen_fifo #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_imm,
    output logic [2:0]               out_fmt,
    output logic                     out_illegal,
    output logic [TAG_W-1:0]         out_tag,
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    output logic [15:0]              illegal_cnt,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    // storage and pointers
    logic [XLEN-1:0]  imm_mem_q [DEPTH];
    logic [XLEN-1:0]  imm_mem_d [DEPTH];
    logic [2:0]       fmt_mem_q [DEPTH];
    logic [2:0]       fmt_mem_d [DEPTH];
    logic             ill_mem_q [DEPTH];
    logic             ill_mem_d [DEPTH];
    logic [TAG_W-1:0] tag_mem_q [DEPTH];
    logic [TAG_W-1:0] tag_mem_d [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push;
    logic             pop;

    logic [31:0]      dec_imm32;
    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_ill;

`ifdef IMM_GEN_ILLEGAL_CNT_EN
    logic [15:0]      illegal_cnt_q, illegal_cnt_d;
`endif

    // Opcode decode and 32-bit immediate assembly, then sign-extend to XLEN
    always_comb begin
        dec_imm32 = 32'd0;
        dec_fmt   = FMT_ILL;
        dec_ill   = 1'b1;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec_fmt   = FMT_I;
                dec_ill   = 1'b0;
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec_fmt   = FMT_S;
                dec_ill   = 1'b0;
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_fmt   = FMT_B;
                dec_ill   = 1'b0;
                dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt   = FMT_U;
                dec_ill   = 1'b0;
                dec_imm32 = {in_instr[31:12], 12'd0};
            end
            7'b1101111: begin
                dec_fmt   = FMT_J;
                dec_ill   = 1'b0;
                dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b0110011: begin
                dec_fmt   = FMT_R;
                dec_ill   = 1'b0;
                dec_imm32 = 32'd0;
            end
            default: begin
                dec_fmt   = FMT_ILL;
                dec_ill   = 1'b1;
                dec_imm32 = 32'd0;
            end
        endcase
        dec_imm = XLEN'($signed(dec_imm32));
    end

    // Handshake flags; a full FIFO refuses even when a pop happens the same cycle
    always_comb begin
        in_ready  = (count_q != CNT_W'(DEPTH));
        out_valid = (count_q != CNT_W'(0));
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Next-state for pointers, occupancy and entry write
    always_comb begin
        imm_mem_d = imm_mem_q;
        fmt_mem_d = fmt_mem_q;
        ill_mem_d = ill_mem_q;
        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            imm_mem_d[wr_ptr_q] = dec_imm;
            fmt_mem_d[wr_ptr_q] = dec_fmt;
            ill_mem_d[wr_ptr_q] = dec_ill;
            tag_mem_d[wr_ptr_q] = in_tag;
        end
    end

    // State registers; reset empties the queue immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                imm_mem_q[i] <= '0;
                fmt_mem_q[i] <= '0;
                ill_mem_q[i] <= 1'b0;
                tag_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            imm_mem_q <= imm_mem_d;
            fmt_mem_q <= fmt_mem_d;
            ill_mem_q <= ill_mem_d;
            tag_mem_q <= tag_mem_d;
        end
    end

    // Head entry presentation; data reads zero while empty
    always_comb begin
        count       = count_q;
        out_imm     = '0;
        out_fmt     = 3'd0;
        out_illegal = 1'b0;
        out_tag     = '0;
        if (out_valid) begin
            out_imm     = imm_mem_q[rd_ptr_q];
            out_fmt     = fmt_mem_q[rd_ptr_q];
            out_illegal = ill_mem_q[rd_ptr_q];
            out_tag     = tag_mem_q[rd_ptr_q];
        end
    end

`ifdef IMM_GEN_ILLEGAL_CNT_EN
    // Saturating count of accepted illegal words
    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (push && dec_ill && (illegal_cnt_q != 16'hFFFF)) begin
            illegal_cnt_d = illegal_cnt_q + 16'd1;
        end
    end

    // Illegal counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt_q <= 16'd0;
        end else begin
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    // Counter output
    always_comb begin
        illegal_cnt = illegal_cnt_q;
    end
`endif

endmodule

// File: tb/tb_imm_gen_fifo.sv
// Testbench for imm_gen_fifo: table vectors, hand sequences for full/reset
// corners, and randomized traffic against a queue-based reference model.
// A second instance with XLEN=64 shares all inputs to check wide extension.
module tb_imm_gen_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    logic             in_ready, out_valid, out_illegal;
    logic [31:0]      out_imm;
    logic [2:0]       out_fmt;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       count;

    logic             in_ready64, out_valid64, out_illegal64;
    logic [63:0]      out_imm64;
    logic [2:0]       out_fmt64;
    logic [TAG_W-1:0] out_tag64;
    logic [2:0]       count64;

`ifdef IMM_GEN_ILLEGAL_CNT_EN
    logic [15:0]      illegal_cnt, illegal_cnt64;
`endif

    imm_gen_fifo #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag),
`ifdef IMM_GEN_ILLEGAL_CNT_EN
        .illegal_cnt(illegal_cnt),
`endif
        .count(count)
    );

    imm_gen_fifo #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64),
`ifdef IMM_GEN_ILLEGAL_CNT_EN
        .illegal_cnt(illegal_cnt64),
`endif
        .count(count64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } m_ent_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    m_ent_t           m_q [$];
    int               total = 0;
    int               bad   = 0;
    logic             last_push;
    logic [TAG_W-1:0] last_tag;
    logic [15:0]      m_ill_cnt = 16'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode written from the format rules with integer arithmetic
    function automatic m_ent_t model_dec(input logic [31:0] w, input logic [TAG_W-1:0] t);
        m_ent_t m;
        int     s;
        int     v;
        m.tag = t;
        m.ill = 1'b0;
        m.imm = 32'd0;
        m.fmt = 3'd0;
        s     = $signed(w);
        case (w[6:0])
            7'h13, 7'h03, 7'h67: begin
                m.fmt = 3'd1;
                m.imm = 32'(s >>> 20);
            end
            7'h23: begin
                m.fmt = 3'd2;
                m.imm = 32'((s >>> 25) * 32) | ((w >> 7) & 32'h1F);
            end
            7'h63: begin
                m.fmt = 3'd3;
                v = int'(w[7]) * 2048 + int'((w >> 25) & 32'h3F) * 32 + int'((w >> 8) & 32'hF) * 2;
                if (w[31]) v = v - 4096;
                m.imm = 32'(v);
            end
            7'h37, 7'h17: begin
                m.fmt = 3'd4;
                m.imm = w & 32'hFFFFF000;
            end
            7'h6F: begin
                m.fmt = 3'd5;
                v = int'((w >> 12) & 32'hFF) * 4096 + int'(w[20]) * 2048 + int'((w >> 21) & 32'h3FF) * 2;
                if (w[31]) v = v - (1 << 20);
                m.imm = 32'(v);
            end
            7'h33: m.fmt = 3'd0;
            default: begin
                m.fmt = 3'd7;
                m.ill = 1'b1;
            end
        endcase
        return m;
    endfunction

    // One clock: compare DUT against model at negedge, then advance the model
    task automatic cycle();
        logic   do_push, do_pop;
        m_ent_t e;
        chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(m_q.size() != int'(DEPTH)));
        chk("count", 64'(count), 64'(m_q.size()));
        chk("count64", 64'(count64), 64'(m_q.size()));
        chk("out_valid64", 64'(out_valid64), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            e = m_q[0];
            chk("head_imm", 64'(out_imm), 64'(e.imm));
            chk("head_imm64", out_imm64, {{32{e.imm[31]}}, e.imm});
            chk("head_fmt", 64'(out_fmt), 64'(e.fmt));
            chk("head_ill", 64'(out_illegal), 64'(e.ill));
            chk("head_tag", 64'(out_tag), 64'(e.tag));
        end else begin
            chk("empty_imm", 64'(out_imm), 64'd0);
            chk("empty_tag", 64'(out_tag), 64'd0);
        end
`ifdef IMM_GEN_ILLEGAL_CNT_EN
        chk("illegal_cnt", 64'(illegal_cnt), 64'(m_ill_cnt));
`endif
        do_push = in_valid && (m_q.size() < int'(DEPTH));
        do_pop  = (m_q.size() != 0) && out_ready;
        @(posedge clk);
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            e = model_dec(in_instr, in_tag);
            m_q.push_back(e);
            if (e.ill && m_ill_cnt != 16'hFFFF) m_ill_cnt = m_ill_cnt + 16'd1;
        end
        last_push = do_push;
        last_tag  = in_tag;
        @(negedge clk);
    endtask

    vec_t       vecs [10];
    logic [6:0] ops  [12];
    int         next_exp;

    initial begin
        vecs[0] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0};
        vecs[1] = '{32'hFE512E23, 32'hFFFFFFFC, 3'd2, 1'b0};
        vecs[2] = '{32'hFE000FE3, 32'hFFFFFFFE, 3'd3, 1'b0};
        vecs[3] = '{32'h0010006F, 32'h00000800, 3'd5, 1'b0};
        vecs[4] = '{32'h800000B7, 32'h80000000, 3'd4, 1'b0};
        vecs[5] = '{32'h0000007F, 32'h00000000, 3'd7, 1'b1};
        vecs[6] = '{32'h00B50533, 32'h00000000, 3'd0, 1'b0};
        vecs[7] = '{32'h12345017, 32'h12345000, 3'd4, 1'b0};
        vecs[8] = '{32'h00412083, 32'h00000004, 3'd1, 1'b0};
        vecs[9] = '{32'h800080E7, 32'hFFFFF800, 3'd1, 1'b0};
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h00, 7'h0B};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_tag    = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // table vectors: push one word, check the head next cycle, let it pop
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_tag   = TAG_W'(i + 8'h40);
            cycle();
            in_valid = 1'b0;
            chk("vec_valid", 64'(out_valid), 64'd1);
            chk("vec_imm", 64'(out_imm), 64'(vecs[i].imm));
            chk("vec_imm64", out_imm64, {{32{vecs[i].imm[31]}}, vecs[i].imm});
            chk("vec_fmt", 64'(out_fmt), 64'(vecs[i].fmt));
            chk("vec_ill", 64'(out_illegal), 64'(vecs[i].ill));
            cycle();
        end

        // full boundary: tags 1..5 with consumer stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00000013;
        for (int k = 1; k <= 4; k++) begin
            in_tag = TAG_W'(k);
            cycle();
        end
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_count", 64'(count), 64'd4);
        in_tag = TAG_W'(5);
        cycle();
        cycle();
        chk("held_count", 64'(count), 64'd4);
        out_ready = 1'b1;
        next_exp  = 1;
        for (int i = 0; i < 12 && next_exp <= 5; i++) begin
            if (out_valid) begin
                chk("pop_order", 64'(out_tag), 64'(next_exp));
                next_exp++;
            end
            cycle();
            if (last_push && last_tag == TAG_W'(5)) in_valid = 1'b0;
        end
        chk("all_popped", 64'(next_exp), 64'd6);

        // simultaneous push and pop at count 2
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_tag = TAG_W'(8'h80 + k);
            cycle();
        end
        out_ready = 1'b1;
        for (int k = 2; k < 12; k++) begin
            in_tag   = TAG_W'(8'h80 + k);
            in_instr = 32'h00100093 + 32'(k << 20);
            chk("pp_count", 64'(count), 64'd2);
            cycle();
        end
        in_valid = 1'b0;
        repeat (3) cycle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_instr  = $urandom();
            in_instr[6:0] = ops[$urandom_range(0, 11)];
            in_tag    = TAG_W'($urandom());
            cycle();
        end

        // asynchronous reset mid-stream with three entries queued
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 1) cycle();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_tag   = TAG_W'(8'hA0 + k);
            in_instr = 32'h0000007F;
            cycle();
        end
        in_valid = 1'b0;
        chk("pre_rst_count", 64'(count), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_imm", 64'(out_imm), 64'd0);
        m_q.delete();
        m_ill_cnt = 16'd0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) cycle();

`ifdef IMM_GEN_ILLEGAL_CNT_EN
        // illegal counter increment and saturation from a forced preload
        in_valid = 1'b1;
        in_instr = 32'h0000007F;
        cycle();
        in_valid = 1'b0;
        chk("ill_cnt_one", 64'(illegal_cnt), 64'd1);
        force dut.illegal_cnt_q   = 16'hFFFE;
        force dut64.illegal_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.illegal_cnt_q;
        release dut64.illegal_cnt_q;
        m_q.delete();
        m_ill_cnt = 16'hFFFE;
        in_valid  = 1'b1;
        repeat (3) cycle();
        in_valid = 1'b0;
        cycle();
        chk("ill_cnt_sat", 64'(illegal_cnt), 64'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
